// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD CMD-line engine; serialises 48-bit command frames and captures 48/136-bit responses.
// Define SD_CMD_CRC_CHECK_EN to compile in the response CRC7 checker (error bit 1).
module sd_cmd_engine #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  command,
    input  logic [31:0]  argument,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         busy,
    output logic         command_complete,
    output logic [127:0] response_o,
    output logic [15:0]  error_interrupt_status_o,
    output logic [15:0]  normal_interrupt_status_o
);

    localparam int WCW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [47:0]    txShift_q, txShift_d;
    logic [7:0]     bitCnt_q, bitCnt_d;
    logic [WCW-1:0] waitCnt_q, waitCnt_d;
    logic [126:0]   rxShift_q, rxShift_d;
    logic [5:0]     cmdIdx_q, cmdIdx_d;
    logic           idxChk_q, idxChk_d;
    logic           longResp_q, longResp_d;
    logic           noResp_q, noResp_d;
    logic           cmdOut_q, cmdOut_d;
    logic           cmdOe_q, cmdOe_d;
    logic [127:0]   resp_q, resp_d;
    logic [3:0]     errStat_q, errStat_d;
    logic           normStat_q, normStat_d;
    logic [127:0]   rxFrame;
    logic           unusedCmdBits;
`ifdef SD_CMD_CRC_CHECK_EN
    logic           crcChk_q, crcChk_d;
    logic [6:0]     rxCrc_q, rxCrc_d;
`endif

    function automatic logic [6:0] crcStep(input logic [6:0] crc, input logic bitIn);
        logic fb;
        fb = bitIn ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    function automatic logic [6:0] crc7Of40(input logic [39:0] data);
        logic [6:0] crc;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            crc = crcStep(crc, data[i]);
        end
        return crc;
    endfunction

    // The most recent 128 received bits, including the bit being sampled this cycle
    assign rxFrame = {rxShift_q, cmd_in};

`ifdef SD_CMD_CRC_CHECK_EN
    assign unusedCmdBits = ^{command[15:14], command[7:5], command[2]};
`else
    assign unusedCmdBits = ^{command[15:14], command[7:5], command[3:2]};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            txShift_q  <= '1;
            bitCnt_q   <= '0;
            waitCnt_q  <= '0;
            rxShift_q  <= '0;
            cmdIdx_q   <= '0;
            idxChk_q   <= 1'b0;
            longResp_q <= 1'b0;
            noResp_q   <= 1'b0;
            cmdOut_q   <= 1'b1;
            cmdOe_q    <= 1'b0;
            resp_q     <= '0;
            errStat_q  <= '0;
            normStat_q <= 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
            crcChk_q   <= 1'b0;
            rxCrc_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            txShift_q  <= txShift_d;
            bitCnt_q   <= bitCnt_d;
            waitCnt_q  <= waitCnt_d;
            rxShift_q  <= rxShift_d;
            cmdIdx_q   <= cmdIdx_d;
            idxChk_q   <= idxChk_d;
            longResp_q <= longResp_d;
            noResp_q   <= noResp_d;
            cmdOut_q   <= cmdOut_d;
            cmdOe_q    <= cmdOe_d;
            resp_q     <= resp_d;
            errStat_q  <= errStat_d;
            normStat_q <= normStat_d;
`ifdef SD_CMD_CRC_CHECK_EN
            crcChk_q   <= crcChk_d;
            rxCrc_q    <= rxCrc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        txShift_d  = txShift_q;
        bitCnt_d   = bitCnt_q;
        waitCnt_d  = waitCnt_q;
        rxShift_d  = rxShift_q;
        cmdIdx_d   = cmdIdx_q;
        idxChk_d   = idxChk_q;
        longResp_d = longResp_q;
        noResp_d   = noResp_q;
        cmdOut_d   = 1'b1;
        cmdOe_d    = 1'b0;
        resp_d     = resp_q;
        errStat_d  = errStat_q;
        normStat_d = normStat_q;
`ifdef SD_CMD_CRC_CHECK_EN
        crcChk_d   = crcChk_q;
        rxCrc_d    = rxCrc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    txShift_d  = {2'b01, command[13:8], argument,
                                  crc7Of40({2'b01, command[13:8], argument}), 1'b1};
                    bitCnt_d   = '0;
                    cmdIdx_d   = command[13:8];
                    idxChk_d   = command[4];
                    longResp_d = (command[1:0] == 2'b01);
                    noResp_d   = (command[1:0] == 2'b00);
                    errStat_d  = '0;
                    normStat_d = 1'b0;
`ifdef SD_CMD_CRC_CHECK_EN
                    crcChk_d   = command[3];
`endif
                end
            end
            // First SEND cycle only loads the output register, so bit k lands in cycle 1+k
            SEND: begin
                if (bitCnt_q == 8'd48) begin
                    bitCnt_d  = '0;
                    waitCnt_d = '0;
                    state_d   = noResp_q ? DONE : WAIT;
                end else begin
                    cmdOut_d  = txShift_q[47];
                    cmdOe_d   = 1'b1;
                    txShift_d = {txShift_q[46:0], 1'b1};
                    bitCnt_d  = bitCnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (!cmd_in) begin
                    state_d   = RECV;
                    bitCnt_d  = 8'd1;
                    rxShift_d = {rxShift_q[125:0], cmd_in};
`ifdef SD_CMD_CRC_CHECK_EN
                    rxCrc_d   = '0;
`endif
                end else if (waitCnt_q == WCW'(RESP_TIMEOUT - 1)) begin
                    state_d      = DONE;
                    errStat_d[0] = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + WCW'(1);
                end
            end
            // bitCnt_q is the position of the bit sampled this cycle; the start bit was position 0
            RECV: begin
                rxShift_d = {rxShift_q[125:0], cmd_in};
                bitCnt_d  = bitCnt_q + 8'd1;
`ifdef SD_CMD_CRC_CHECK_EN
                if (longResp_q ? (bitCnt_q >= 8'd8 && bitCnt_q <= 8'd127) : (bitCnt_q <= 8'd39)) begin
                    rxCrc_d = crcStep(rxCrc_q, cmd_in);
                end
`endif
                if (bitCnt_q == (longResp_q ? 8'd135 : 8'd47)) begin
                    state_d = DONE;
                    resp_d  = longResp_q ? rxFrame : {96'b0, rxFrame[39:8]};
                    if (!rxFrame[0]) begin
                        errStat_d[2] = 1'b1;
                    end
                    if (!longResp_q && idxChk_q && (rxFrame[45:40] != cmdIdx_q)) begin
                        errStat_d[3] = 1'b1;
                    end
`ifdef SD_CMD_CRC_CHECK_EN
                    if (crcChk_q && (rxFrame[7:1] != rxCrc_q)) begin
                        errStat_d[1] = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DONE) begin
            normStat_d = 1'b1;
        end
    end

    assign cmd_out                   = cmdOut_q;
    assign cmd_oe                    = cmdOe_q;
    assign busy                      = (state_q != IDLE);
    assign command_complete          = (state_q == DONE);
    assign response_o                = resp_q;
    assign error_interrupt_status_o  = {12'b0, errStat_q};
    assign normal_interrupt_status_o = {15'b0, normStat_q};

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed self-checking bench for sd_cmd_engine (transmit framing, responses,
// timeout, error flags, busy-start rejection and mid-receive reset).
module tb_sd_cmd_engine;

    logic         clock;
    logic         reset;
    logic         start;
    logic [15:0]  command;
    logic [31:0]  argument;
    logic         cmd_in;
    logic         cmd_out;
    logic         cmd_oe;
    logic         busy;
    logic         command_complete;
    logic [127:0] response_o;
    logic [15:0]  error_interrupt_status_o;
    logic [15:0]  normal_interrupt_status_o;

    int errorCount;
    int checkCount;

    sd_cmd_engine #(.RESP_TIMEOUT(64)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .start                     (start),
        .command                   (command),
        .argument                  (argument),
        .cmd_in                    (cmd_in),
        .cmd_out                   (cmd_out),
        .cmd_oe                    (cmd_oe),
        .busy                      (busy),
        .command_complete          (command_complete),
        .response_o                (response_o),
        .error_interrupt_status_o  (error_interrupt_status_o),
        .normal_interrupt_status_o (normal_interrupt_status_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Bench-side CRC7 (x^7+x^3+1) over the low n bits of data, MSB first, used to build response frames
    function automatic logic [6:0] crc7(input logic [127:0] data, input int n);
        logic [6:0] crc;
        logic fb;
        crc = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    // Issues one command (start accepted at edge 0) and runs it cycle by cycle; cycle c is sampled
    // and driven at the falling edge inside it
    task automatic applyStimulus(input logic [15:0] cmdVal, input logic [31:0] argVal,
                                 input int respLen, input int respDelay, input logic [135:0] respFrame,
                                 input int glitchCycle, input int resetCycle,
                                 output logic [47:0] txBits, output int doneCycle, output logic oeOk,
                                 output logic busyAfter, output logic pulseAfter,
                                 output logic rstOe, output logic rstBusy);
        int limit;
        int idx;
        txBits     = '0;
        doneCycle  = -1;
        oeOk       = 1'b1;
        busyAfter  = 1'b1;
        pulseAfter = 1'b1;
        rstOe      = 1'b1;
        rstBusy    = 1'b1;
        limit      = (resetCycle >= 0) ? resetCycle + 10 : 400;
        @(negedge clock);
        command  = cmdVal;
        argument = argVal;
        start    = 1'b1;
        @(posedge clock);
        for (int c = 0; c < limit; c++) begin
            @(negedge clock);
            if (c >= 1 && c <= 48) begin
                txBits[48 - c] = cmd_out;
                if (!cmd_oe) oeOk = 1'b0;
            end
            if (c == 49 && (cmd_oe || !cmd_out)) oeOk = 1'b0;
            if (command_complete && doneCycle < 0) doneCycle = c;
            if (doneCycle >= 0 && c == doneCycle + 1) begin
                busyAfter  = busy;
                pulseAfter = command_complete;
            end
            if (resetCycle >= 0 && c == resetCycle + 1) begin
                rstOe   = cmd_oe;
                rstBusy = busy;
            end
            idx    = c - 49 - respDelay;
            cmd_in = (respLen > 0 && idx >= 0 && idx < respLen) ? respFrame[respLen - 1 - idx] : 1'b1;
            start  = (c == glitchCycle);
            if (resetCycle >= 0 && c == resetCycle) reset = 1'b0;
            if (resetCycle >= 0 && c == resetCycle + 2) reset = 1'b1;
            if (doneCycle >= 0 && c == doneCycle + 1) break;
        end
        cmd_in = 1'b1;
        start  = 1'b0;
        reset  = 1'b1;
    endtask

    logic [47:0]  txBits;
    int           doneCycle;
    logic         oeOk, busyAfter, pulseAfter, rstOe, rstBusy;
    logic [39:0]  idx9Data;
    logic [47:0]  idx9Frame;
    logic [119:0] cid;
    logic [135:0] frame136;
    logic [15:0]  expFlipEnd;
    logic [15:0]  expFlipOnly;

    initial begin
        errorCount = 0;
        checkCount = 0;
        reset    = 1'b0;
        start    = 1'b0;
        command  = '0;
        argument = '0;
        cmd_in   = 1'b1;

`ifdef SD_CMD_CRC_CHECK_EN
        expFlipEnd  = 16'h0006;
        expFlipOnly = 16'h0002;
`else
        expFlipEnd  = 16'h0004;
        expFlipOnly = 16'h0000;
`endif

        idx9Data  = {8'h09, 32'h000001AA};
        idx9Frame = {idx9Data, crc7({88'h0, idx9Data}, 40), 1'b1};
        cid       = 120'h0123456789ABCDEFFEDCBA98765432;
        frame136  = {2'b00, 6'h3F, cid, crc7({8'h0, cid}, 120), 1'b1};

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("rst_cmd_out", 128'(cmd_out), 128'd1);
        checkOutput("rst_cmd_oe", 128'(cmd_oe), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_complete", 128'(command_complete), 128'd0);
        checkOutput("rst_response", response_o, 128'd0);
        checkOutput("rst_err", 128'(error_interrupt_status_o), 128'd0);
        checkOutput("rst_norm", 128'(normal_interrupt_status_o), 128'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // CMD0, no response
        applyStimulus(16'h0000, 32'h0, 0, 0, 136'h0, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("cmd0_tx", 128'(txBits), 128'h400000000095);
        checkOutput("cmd0_oe", 128'(oeOk), 128'd1);
        checkOutput("cmd0_done_cycle", 128'(doneCycle), 128'd49);
        checkOutput("cmd0_busy_after", 128'(busyAfter), 128'd0);
        checkOutput("cmd0_pulse_width", 128'(pulseAfter), 128'd0);
        checkOutput("cmd0_err", 128'(error_interrupt_status_o), 128'h0000);
        checkOutput("cmd0_norm", 128'(normal_interrupt_status_o), 128'h0001);

        // CMD8 with a clean R7 response after 5 idle cycles
        applyStimulus(16'h081A, 32'h000001AA, 48, 5, 136'h08000001AA13, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("cmd8_tx", 128'(txBits), 128'h48000001AA87);
        checkOutput("cmd8_oe", 128'(oeOk), 128'd1);
        checkOutput("cmd8_done_cycle", 128'(doneCycle), 128'd102);
        checkOutput("cmd8_busy_after", 128'(busyAfter), 128'd0);
        checkOutput("cmd8_response", response_o, 128'h1AA);
        checkOutput("cmd8_err", 128'(error_interrupt_status_o), 128'h0000);
        checkOutput("cmd8_norm", 128'(normal_interrupt_status_o), 128'h0001);

        // Timeout: no start bit ever arrives
        applyStimulus(16'h081A, 32'h000001AA, 0, 0, 136'h0, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("tmo_done_cycle", 128'(doneCycle), 128'd113);
        checkOutput("tmo_err", 128'(error_interrupt_status_o), 128'h0001);
        checkOutput("tmo_response", response_o, 128'h1AA);
        checkOutput("tmo_norm", 128'(normal_interrupt_status_o), 128'h0001);

        // Argument bit flipped and end bit cleared
        applyStimulus(16'h081A, 32'h000001AA, 48, 5, 136'h08000001AB12, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("flipend_done_cycle", 128'(doneCycle), 128'd102);
        checkOutput("flipend_err", 128'(error_interrupt_status_o), 128'(expFlipEnd));
        checkOutput("flipend_response", response_o, 128'h1AB);

        // Wrong index, CRC valid for the altered frame
        applyStimulus(16'h081A, 32'h000001AA, 48, 2, 136'(idx9Frame), -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("index_done_cycle", 128'(doneCycle), 128'd99);
        checkOutput("index_err", 128'(error_interrupt_status_o), 128'h0008);
        checkOutput("index_response", response_o, 128'h1AA);

        // CRC corruption alone
        applyStimulus(16'h081A, 32'h000001AA, 48, 0, 136'h08000001AB13, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("crcflip_done_cycle", 128'(doneCycle), 128'd97);
        checkOutput("crcflip_err", 128'(error_interrupt_status_o), 128'(expFlipOnly));
        checkOutput("crcflip_response", response_o, 128'h1AB);

        // CMD2 with a 136-bit response and a stray start pulse during RECV
        applyStimulus(16'h0209, 32'h0, 136, 3, frame136, 49 + 3 + 50, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("cmd2_tx", 128'(txBits), 128'h42000000004D);
        checkOutput("cmd2_done_cycle", 128'(doneCycle), 128'd188);
        checkOutput("cmd2_busy_after", 128'(busyAfter), 128'd0);
        checkOutput("cmd2_response", response_o, frame136[127:0]);
        checkOutput("cmd2_err", 128'(error_interrupt_status_o), 128'h0000);
        checkOutput("cmd2_norm", 128'(normal_interrupt_status_o), 128'h0001);

        // Same exchange, reset asserted in the middle of RECV
        applyStimulus(16'h0209, 32'h0, 136, 3, frame136, -1, 49 + 3 + 60,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("abort_cmd_oe", 128'(rstOe), 128'd0);
        checkOutput("abort_busy", 128'(rstBusy), 128'd0);
        checkOutput("abort_no_complete", 128'(doneCycle), 128'(-1));
        checkOutput("abort_response", response_o, 128'd0);
        checkOutput("abort_norm", 128'(normal_interrupt_status_o), 128'h0000);

        // Engine still usable after the abort
        applyStimulus(16'h0000, 32'h0, 0, 0, 136'h0, -1, -1,
                      txBits, doneCycle, oeOk, busyAfter, pulseAfter, rstOe, rstBusy);
        checkOutput("post_abort_tx", 128'(txBits), 128'h400000000095);
        checkOutput("post_abort_done_cycle", 128'(doneCycle), 128'd49);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Serial command-line engine of the SD host controller. It takes the command and argument values held by the host register block, serialises a 48-bit command frame onto the SD CMD line, and waits for the card's response. It then captures the 48- or 136-bit response, checks it, and returns response data, interrupt status and a one-cycle `command_complete` pulse to the register block. One CMD bit is transferred per `clock` cycle, so `clock` is the SD card clock.

## Interface
- `RESP_TIMEOUT`, default 64: maximum number of cycles to wait for a response start bit after the command end bit.
- `clock`  in  1  the single clock for the block; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to issue a command; sampled only in IDLE.
- `command`  in  16  from the register block. [13:8] = command index; [4] = index check enable; [3] = CRC check enable; [1:0] = response type (00 none, 01 136-bit, 10 48-bit, 11 48-bit with busy; 11 is handled as 10).
- `argument`  in  32  command argument.
- `cmd_in`  in  1  CMD line input from the card.
- `cmd_out`  out  1  CMD line output data.
- `cmd_oe`  out  1  CMD line output enable.
- `busy`  out  1  high from acceptance of `start` until `command_complete`.
- `command_complete`  out  1  one-cycle completion pulse.
- `response_o`  out  128  captured response data.
- `error_interrupt_status_o`  out  16  error flags: [0] timeout; [1] CRC error; [2] end-bit error; [3] index error; [15:4] always 0.
- `normal_interrupt_status_o`  out  16  [0] is set on command complete; [15:1] always 0.

## Operation
- States and transitions:
  - IDLE -> SEND on `start`.
  - SEND -> WAIT, or SEND -> DONE when the response type is none.
  - WAIT -> RECV on the response start bit, or WAIT -> DONE on timeout.
  - RECV -> DONE.
  - DONE -> IDLE.
- Acceptance in IDLE:
  - `command` and `argument` are latched.
  - Both status outputs are cleared.
  - `busy` rises.
- SEND:
  - Frame sent MSB first: {0, 1, index[5:0], argument[31:0], CRC7[6:0], 1}.
  - CRC7 polynomial is x^7+x^3+1 with initial value 0, computed over the first 40 bits.
- WAIT:
  - The cycle counter increments while `cmd_in`=1.
  - The first `cmd_in`=0 is taken as the response start bit.
  - When the counter reaches `RESP_TIMEOUT`: set error [0] and go to DONE; `response_o` is left unchanged.
- RECV:
  - Shifts in 48 or 136 bits in total, counting the start bit.
  - 48-bit response: `response_o` = {96'b0, frame[39:8]}.
    - Index check (if enabled): frame[45:40] must equal the command index, otherwise error [3].
    - CRC check (if enabled): CRC7 over frame[47:8] must equal frame[7:1], otherwise error [1].
  - 136-bit response: `response_o` = frame[127:0].
    - CRC check is over frame[127:8] against frame[7:1].
    - No index check.
  - End bit frame[0] must be 1, otherwise error [2].
  - Error flags accumulate; several may be set together.
  - `response_o` is updated even when CRC, index or end-bit errors are flagged.
- DONE:
  - `command_complete` is pulsed.
  - `normal_interrupt_status_o[0]` is set.
  - `busy` drops.
- `start` while `busy` is ignored and does not affect the command in progress.
- Status and `response_o` hold until the next accepted `start` (status) or the next successful capture (`response_o`).

## Timing
- Reset values:
  - `cmd_out`=1, `cmd_oe`=0.
  - `busy`=0, `command_complete`=0.
  - `response_o`=0.
  - Both status outputs = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately, without a completion pulse, and returns all outputs to their reset values.
- Let `start` be accepted on the edge of cycle 0.
- Transmit:
  - Frame bit k appears on `cmd_out` with `cmd_oe`=1 in cycle 1+k, for k=0..47.
  - `cmd_oe`=0 and `cmd_out`=1 from cycle 49.
- No-response command: `command_complete` is high in cycle 49.
- Response wait: the cycle counter starts at cycle 49.
- Response reception:
  - The last response bit is sampled in cycle N.
  - Checks are registered and `command_complete` is high in cycle N+1.
  - `busy` is low from cycle N+2.
- Timeout: `command_complete` is high in cycle 49+`RESP_TIMEOUT`.
- A new `start` is accepted no earlier than the cycle after `command_complete`.

## Configuration
- `SD_CMD_CRC_CHECK_EN` defined:
  - Response CRC7 checker is compiled in.
  - Error [1] behaves as described above.
- `SD_CMD_CRC_CHECK_EN` undefined:
  - Checker logic is absent.
  - Error [1] is constant 0, and `command[3]` is ignored.
  - Transmit CRC generation is always present.

## Test plan
- CMD0, `command`=16'h0000, `argument`=0:
  - `cmd_out` serialises 48'h400000000095.
  - `command_complete` in cycle 49; error status 16'h0000.
- CMD8, `command`=16'h081A, `argument`=32'h000001AA, transmit:
  - `cmd_out` serialises 48'h48000001AA87.
- Same CMD8, response:
  - The bench drives response 48'h08000001AA13 after 5 idle cycles.
  - `response_o`=128'h1AA, error status 16'h0000, normal status 16'h0001.
- Timeout:
  - `cmd_in` held at 1 with `RESP_TIMEOUT`=64 and a 48-bit response type.
  - `command_complete` in cycle 113; error status 16'h0001; `response_o` unchanged.
- Corrupted response on the CMD8 exchange:
  - Flip argument bit 0 and set the end bit to 0 -> error status 16'h0006.
  - Change the response index to 6'h09 instead -> error status 16'h0008.
  - Build without the macro: the CRC flip alone -> error status 16'h0000.
- 136-bit response:
  - `command`=16'h0209; the bench drives 136 bits with a valid CRC.
  - `response_o` equals frame[127:0].
  - Pulsing `start` during RECV has no effect.
  - Asserting `reset` low mid-RECV: `cmd_oe`=0, `busy`=0, and no `command_complete` pulse.
